bcd_updown_counter_n: RTL
=========================

// Module: bcd_updown_counter_n
// PURPOSE
//  Parametrised NDIG-digit BCD up/down counter for seven-segment display paths.
//  Adds over the 3-digit counter: synchronous clear, parallel load with BCD validation,
//  wrap or saturate mode, terminal-count flag, and overflow/underflow flags.
//  Sits between control logic (buttons/FSM) and the per-digit seven-segment decoders.
// PARAMETERS
//  NDIG  3  number of BCD digits (1..8); count width = 4*NDIG
//  WRAP  1  1: wrap at terminal (99..9 <-> 00..0); 0: saturate at terminal
// PORTS
//  clk       in   1        rising-edge clock
//  rst       in   1        asynchronous, active-high reset
//  en        in   1        count enable; one step per cycle while high
//  up        in   1        direction: 1 = increment, 0 = decrement
//  clr       in   1        synchronous clear to 0
//  load      in   1        synchronous parallel load of load_val
//  load_val  in   4*NDIG   load data; digit i = load_val[4i+3:4i], digit 0 = LSD
//  count     out  4*NDIG   registered BCD count, same digit packing
//  tc        out  1        comb.: count at terminal for current up (all 9s up, all 0s down)
//  ovf       out  1        registered 1-cycle pulse: a step hit terminal (wrapped or blocked)
//  ovf_stk   out  1        sticky ovf; cleared only by rst, clr or load
//  load_err  out  1        registered 1-cycle pulse: load_val had a digit > 9
// BEHAVIOUR
//  - One clock, single always block for state; async rst sets count=0, ovf=0,
//    ovf_stk=0, load_err=0 immediately, regardless of clk.
//  - Per-edge priority: clr > load > en. Inputs sampled on rising clk edge; results
//    visible on count the cycle after (latency 1).
//  - clr: count<=0, ovf<=0, ovf_stk<=0, load_err<=0.
//  - load: each digit >9 replaced by 9, others taken as-is; load_err<=1 if any digit
//    was clamped, else 0; ovf<=0; ovf_stk<=0. en ignored that cycle.
//  - en=1, up=1: digit 0 increments; digit i (i>0) steps iff all digits below are 9.
//    A stepping digit at 9 goes to 0. Digit 9 -> 0 when not stepping: unchanged.
//  - en=1, up=0: digit 0 decrements; digit i steps iff all digits below are 0.
//    A stepping digit at 0 goes to 9.
//  - Terminal step (tc=1 and en=1 at edge):
//      WRAP=1: count wraps (99..9 -> 00..0 up, 00..0 -> 99..9 down); ovf<=1.
//      WRAP=0: count holds; ovf<=1 every cycle the blocked step is attempted.
//    ovf_stk<=1 on any terminal step; stays set until clr/load/rst.
//  - ovf, load_err are 0 in every cycle not caused by the event above (pulse width 1).
//  - en=0, no clr/load: count holds; ovf<=0; load_err<=0.
//  - up may change every cycle; direction takes effect on the same edge it is sampled.
//  - tc is combinational from count and up (not gated by en).
//  - count never holds a non-BCD digit (>9) in any reachable state.
//  - rst asserted mid-count: immediate zero; first step after release uses sampled
//    en/up on the first rising edge with rst low.
// TESTING  (NDIG=3 unless stated)
//  1 rst pulse mid-count at 457 -> count=000, flags 0 with no clk edge; en=1,up=1 x12
//    after release -> count=012.
//  2 load 099, up=1, en=1 x2 -> 100 then 101; load 999, step up WRAP=1 -> 000, ovf=1
//    one cycle, ovf_stk=1 held; clr -> ovf_stk=0.
//  3 WRAP=0: load 000, up=0, en=1 x3 -> count stays 000, ovf=1 on all 3 cycles, tc=1.
//  4 load_val=0x3A7 -> count=397, load_err=1 for one cycle; load 0x123 -> load_err=0.
//  5 clr=1,load=1,en=1 same edge from 555 -> 000; load=1,en=1 with load_val 200 -> 200.
//  6 Random up/down/en/clr/load 10k cycles vs integer model (mod 10^NDIG or saturate),
//    NDIG=1 and NDIG=5; every digit checked <=9 each cycle.

Source files
------------

// File: rtl/bcd_updown_counter_n.sv
// NDIG-digit BCD up/down counter for seven-segment display paths.
// Synchronous clear and load (digits above 9 are clamped to 9 and flagged),
// wrap or saturate at the terminal count, a combinational terminal-count flag,
// and registered overflow pulse / sticky overflow flags.
// Digit i occupies bits [4i+3:4i]; digit 0 is the least significant.
module bcd_updown_counter_n #(
   parameter int unsigned NDIG = 3,
   parameter bit          WRAP = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              up,
   input  logic              clr,
   input  logic              load,
   input  logic [4*NDIG-1:0] load_val,
   output logic [4*NDIG-1:0] count,
   output logic              tc,
   output logic              ovf,
   output logic              ovf_stk,
   output logic              load_err
);

   localparam int unsigned W = 4 * NDIG;

   logic [W-1:0]    count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            stk_q, stk_d;
   logic            lerr_q, lerr_d;

   logic [NDIG-1:0] is9, is0;
   logic            all9, all0;
   logic [W-1:0]    step_val;
   logic [W-1:0]    clamp_val;
   logic            any_bad;

   // Per-digit terminal flags feeding the carry/borrow chain and tc.
   always_comb begin
      is9 = '0;
      is0 = '0;
      for (int unsigned i = 0; i < NDIG; i++) begin
         is9[i] = (count_q[4*i +: 4] == 4'd9);
         is0[i] = (count_q[4*i +: 4] == 4'd0);
      end
      all9 = &is9;
      all0 = &is0;
      tc   = up ? all9 : all0;
   end

   // One BCD step in the requested direction; at the terminal this wraps naturally.
   always_comb begin
      logic [3:0] dig;
      logic       carry;
      step_val = count_q;
      for (int unsigned i = 0; i < NDIG; i++) begin
         dig   = count_q[4*i +: 4];
         carry = 1'b1;
         for (int unsigned j = 0; j < i; j++) begin
            carry = carry & (up ? is9[j] : is0[j]);
         end
         if (carry) begin
            if (up) step_val[4*i +: 4] = (dig >= 4'd9) ? 4'd0 : dig + 4'd1;
            else    step_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
         end
      end
   end

   // Load data with every out-of-range digit replaced by 9.
   always_comb begin
      clamp_val = load_val;
      any_bad   = 1'b0;
      for (int unsigned i = 0; i < NDIG; i++) begin
         if (load_val[4*i +: 4] > 4'd9) begin
            clamp_val[4*i +: 4] = 4'd9;
            any_bad             = 1'b1;
         end
      end
   end

   // Next-state selection with priority clr > load > en.
   always_comb begin
      count_d = count_q;
      ovf_d   = 1'b0;
      stk_d   = stk_q;
      lerr_d  = 1'b0;
      if (clr) begin
         count_d = '0;
         stk_d   = 1'b0;
      end else if (load) begin
         count_d = clamp_val;
         lerr_d  = any_bad;
         stk_d   = 1'b0;
      end else if (en) begin
         if (tc) begin
            ovf_d = 1'b1;
            stk_d = 1'b1;
         end
         // Saturating build holds at the terminal; otherwise the step wraps.
         if (!tc || WRAP) count_d = step_val;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         stk_q   <= 1'b0;
         lerr_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         stk_q   <= stk_d;
         lerr_q  <= lerr_d;
      end
   end

   assign count    = count_q;
   assign ovf      = ovf_q;
   assign ovf_stk  = stk_q;
   assign load_err = lerr_q;

endmodule
